// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bits needed to count 0..width-1; never less than one.
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < width) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - b_i, with borrow-out b_o.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic b_i,
    output logic d,
    output logic b_o
);

    assign d   = x ^ y ^ b_i;
    assign b_o = (~x & y) | (~(x ^ y) & b_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - b_in), LSB first, with start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             b_out,
    output logic             ovf
`else
    output logic             b_out
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bo;

    full_subtractor u_cell (
        .x   (sa_q[0]),
        .y   (sb_q[0]),
        .b_i (br_q),
        .d   (cell_d),
        .b_o (cell_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        b_out_d = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = b_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                res_d = {cell_d, res_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = cell_bo;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the result; br_q is the borrow into the MSB stage.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    b_out_d = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = br_q ^ cell_bo;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign b_out = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=4 and WIDTH=8 instances against an arithmetic model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a_i;
    logic [3:0] b_i;
    logic       bin_i;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       b_out;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
    logic       ovf8;
`endif

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       b_out8;

    int n_asserts = 0;
    int n_fail    = 0;
    int n_starts  = 0;
    int n_done    = 0;

    logic [3:0] prev_diff;
    logic       prev_bout;

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .b_in  (bin_i),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .b_out (b_out),
        .ovf   (ovf)
`else
        .b_out (b_out)
`endif
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .b_in  (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
`ifdef SERIAL_SUB_OVF_EN
        .b_out (b_out8),
        .ovf   (ovf8)
`else
        .b_out (b_out8)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Subtraction as plain integer arithmetic: result, unsigned borrow, signed overflow.
    task automatic model(input int w, input int a, input int b, input int bin,
                         output int d, output int bo, output int o);
        int r;
        int sa;
        int sb;
        int sd;
        int m;
        m  = 1 << w;
        r  = a - b - bin;
        d  = (r + 2 * m) % m;
        bo = (r < 0) ? 1 : 0;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        sd = sa - sb - bin;
        o  = (sd < -(m / 2) || sd > (m / 2 - 1)) ? 1 : 0;
    endtask

    // Issue one op on the 4-bit instance starting from a negedge in IDLE or DONE; ends at the done negedge.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin, input bit interfere);
        int ed;
        int eb;
        int eo;
        int busy_cnt;
        bit got;
        model(4, int'(a), int'(b), int'(bin), ed, eb, eo);
        a_i   = a;
        b_i   = b;
        bin_i = bin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_starts++;
        chk("hold_diff", 32'(diff), 32'(prev_diff));
        chk("hold_bout", 32'(b_out), 32'(prev_bout));
        busy_cnt = 0;
        got      = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (interfere && busy_cnt == 2) begin
                start = 1'b1;
                a_i   = 4'($urandom);
                b_i   = 4'($urandom);
                bin_i = 1'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'd4);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("diff", 32'(diff), 32'(ed));
        chk("b_out", 32'(b_out), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(eo));
`endif
        prev_diff = 4'(ed);
        prev_bout = 1'(eb);
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int ed;
        int eb;
        int eo;
        int busy_cnt;
        bit got;
        model(8, int'(a), int'(b), int'(bin), ed, eb, eo);
        a8     = a;
        b8     = b;
        bin8   = bin;
        start8 = 1'b1;
        @(negedge clk);
        start8   = 1'b0;
        busy_cnt = 0;
        got      = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (done8) begin
                got = 1'b1;
                break;
            end
            if (busy8) busy_cnt++;
            @(negedge clk);
        end
        chk("w8_done_seen", 32'(got), 32'd1);
        chk("w8_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("w8_diff", 32'(diff8), 32'(ed));
        chk("w8_b_out", 32'(b_out8), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk("w8_ovf", 32'(ovf8), 32'(eo));
`endif
    endtask

    initial begin
        int snap;
        clk    = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        a_i    = '0;
        b_i    = '0;
        bin_i  = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        bin8   = 1'b0;
        prev_diff = '0;
        prev_bout = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(b_out), 32'd0);
        chk("rst_diff8", 32'(diff8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, including the all-ones borrow-wrap corner.
        do_op(4'd9, 4'd3, 1'b0, 1'b0);
        chk("dir_9m3", 32'(diff), 32'h6);
        do_op(4'd3, 4'd9, 1'b0, 1'b0);
        chk("dir_3m9", 32'(diff), 32'hA);
        do_op(4'd0, 4'd0, 1'b1, 1'b0);
        chk("dir_0m0m1", 32'(diff), 32'hF);
        do_op(4'hF, 4'hF, 1'b1, 1'b0);
        chk("dir_FmFm1_bout", 32'(b_out), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        do_op(4'h8, 4'h1, 1'b0, 1'b0);
        chk("ovf_8m1", 32'(ovf), 32'd1);
        do_op(4'h7, 4'hF, 1'b0, 1'b0);
        chk("ovf_7mF", 32'(ovf), 32'd1);
        do_op(4'h5, 4'h2, 1'b0, 1'b0);
        chk("ovf_5m2", 32'(ovf), 32'd0);
`endif

        // Exhaustive sweep with every start issued in the DONE cycle.
        for (int i = 0; i < 512; i++) begin
            do_op(4'(i >> 5), 4'(i >> 1), 1'(i), 1'b0);
        end
        @(negedge clk);
        chk("done_low_after_done", 32'(done), 32'd0);

        // Random operands with a mid-SHIFT start carrying different operands.
        for (int i = 0; i < 20; i++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
        end

        // Reset in the second SHIFT cycle aborts the op.
        @(negedge clk);
        snap  = n_done;
        a_i   = 4'd2;
        b_i   = 4'd7;
        bin_i = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(b_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("abort_ovf", 32'(ovf), 32'd0);
`endif
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(n_done), 32'(snap));
        prev_diff = '0;
        prev_bout = 1'b0;
        do_op(4'd12, 4'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("done_per_start", 32'(n_done), 32'(n_starts));

        // 8-bit instance: borrow through every bit, then random ops.
        do_op8(8'h00, 8'h01, 1'b0);
        chk("w8_00m01", 32'(diff8), 32'hFF);
        for (int i = 0; i < 10; i++) begin
            do_op8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
